// File: rtl/ser7_clk_fwd_pkg.sv
// Shared types and constants for the forwarded-clock transmitter.
package ser7_clk_fwd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int unsigned DIV_BYPASS = 0;

endpackage

// File: rtl/ser7_clk_fwd_obuf.sv
// Output stage: same-edge DDR register pair feeding a differential pad.
// Portable equivalent of ODDR (SAME_EDGE) + OBUFDS.
module ser7_clk_fwd_obuf (
  input  logic aclk,
  input  logic d1,
  input  logic d2,
  output logic O,
  output logic OB
);

  logic q1;
  logic q2;

  always_ff @(posedge aclk) begin
    q1 <= d1;
    q2 <= d2;
  end

  assign O  = aclk ? q1 : q2;
  assign OB = ~O;

endmodule

// File: rtl/ser7_clk_fwd_tx.sv
// Forwarded-clock transmitter: divides aclk by 2*DIV with glitch-free
// start/stop, continuous or counted-burst operation.
module ser7_clk_fwd_tx
  import ser7_clk_fwd_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned BURST_W  = 16,
  parameter bit          INIT_LOW = 1'b1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               en_req_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               running_o,
  output logic               done_o,
  output logic [BURST_W-1:0] period_cnt_o,
  output logic               fwd_d1_o,
  output logic               fwd_d2_o,
  output logic               O,
  output logic               OB
);

  localparam logic IDLE_LVL = !INIT_LOW;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   hc_q, hc_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] cnt_d, cnt_inc;
  logic               done_d, d1_d, d2_d;
  logic               bypass, last_hc, stop;

  assign running_o = (state_q != ST_IDLE);
  assign cnt_inc   = period_cnt_o + BURST_W'(1);
  assign bypass    = (div_q == DIV_W'(DIV_BYPASS));
  assign last_hc   = (hc_q == div_q);
  assign stop      = !en_req_i || ((len_q != '0) && (cnt_inc == len_q));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    len_d   = len_q;
    hc_d    = hc_q;
    cnt_d   = period_cnt_o;
    done_d  = 1'b0;
    d1_d    = fwd_d1_o;
    d2_d    = fwd_d2_o;

    unique case (state_q)
      ST_IDLE: begin
        d1_d = IDLE_LVL;
        d2_d = IDLE_LVL;
        if (en_req_i) begin
          // hc starts at 1 so each phase lasts exactly div_q cycles
          state_d = ST_HIGH;
          div_d   = div_i;
          len_d   = burst_len_i;
          hc_d    = DIV_W'(1);
          cnt_d   = '0;
          d1_d    = 1'b1;
          d2_d    = (div_i != DIV_W'(DIV_BYPASS));
        end
      end

      ST_HIGH: begin
        if (bypass) begin
          cnt_d = cnt_inc;
          if (stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            d1_d    = IDLE_LVL;
            d2_d    = IDLE_LVL;
          end else begin
            d1_d = 1'b1;
            d2_d = 1'b0;
          end
        end else if (last_hc) begin
          state_d = ST_LOW;
          hc_d    = DIV_W'(1);
          d1_d    = 1'b0;
          d2_d    = 1'b0;
        end else begin
          hc_d = hc_q + DIV_W'(1);
          d1_d = 1'b1;
          d2_d = 1'b1;
        end
      end

      ST_LOW: begin
        if (last_hc) begin
          cnt_d = cnt_inc;
          if (stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            d1_d    = IDLE_LVL;
            d2_d    = IDLE_LVL;
          end else begin
            state_d = ST_HIGH;
            hc_d    = DIV_W'(1);
            d1_d    = 1'b1;
            d2_d    = 1'b1;
          end
        end else begin
          hc_d = hc_q + DIV_W'(1);
          d1_d = 1'b0;
          d2_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      len_q        <= '0;
      hc_q         <= '0;
      period_cnt_o <= '0;
      done_o       <= 1'b0;
      fwd_d1_o     <= IDLE_LVL;
      fwd_d2_o     <= IDLE_LVL;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      len_q        <= len_d;
      hc_q         <= hc_d;
      period_cnt_o <= cnt_d;
      done_o       <= done_d;
      fwd_d1_o     <= d1_d;
      fwd_d2_o     <= d2_d;
    end
  end

  ser7_clk_fwd_obuf u_obuf (
    .aclk (aclk),
    .d1   (fwd_d1_o),
    .d2   (fwd_d2_o),
    .O    (O),
    .OB   (OB)
  );

endmodule
